// File: rtl/stream_rr_arbiter_if.sv
// Stream bundle shared between the round-robin arbiter and its environment.
//   s_axis_*  : N source streams (tdata is an unpacked array, one entry per source)
//   m_axis_*  : the single arbitrated output stream, tagged with the source index
// Modports:
//   master : the arbiter view (consumes sources, drives the output stream)
//   slave  : the environment view (drives sources, consumes the output stream)
interface stream_rr_arbiter_if #(
  parameter int DW   = 24,
  parameter int N    = 4,
  parameter int TIDW = 8
);
  logic [DW-1:0]   s_axis_tdata [N];
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tlast;
  logic [N-1:0]    s_axis_tready;

  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [TIDW-1:0] m_axis_tid;
  logic            m_axis_tlast;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream output between N sources.
// A grant is held until the source's tlast beat, or until MAX_BURST beats
// have been forwarded (MAX_BURST = 0 means packet-bounded only). Each output
// beat carries the index of its source on m_axis_tid.
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   axis      : stream bundle (sources in, tagged output stream out)
//   en_mask   : per-source eligibility for new grants (1 = eligible)
//   busy      : high while a source holds the grant
//   grant_id  : index of the granted source (meaningful while busy)
module stream_rr_arbiter #(
  parameter int DW        = 24,
  parameter int N         = 4,
  parameter int TIDW      = 8,
  parameter int MAX_BURST = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_rr_arbiter_if.master  axis,
  input  logic [N-1:0]         en_mask,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int IW = $clog2(N);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic [TIDW-1:0] m_tid_q, m_tid_d;

  logic [N-1:0]    cand;
  logic            found;
  logic [IW-1:0]   pick;
  int unsigned     idx;
  logic            load;
  logic            accept;
  logic            burst_end;
  logic            release_now;
  logic [N-1:0]    tready;

  // Rotating priority search starting at rr_ptr; modulo keeps non-power-of-2 N correct.
  always_comb begin
    cand  = axis.s_axis_tvalid & en_mask;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(rr_ptr_q) + i) % N;
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // The output register can take a new beat when empty or being drained.
  always_comb begin
    load   = !m_valid_q || axis.m_axis_tready;
    tready = '0;
    if (state_q == GRANT) tready[grant_q] = load;
    accept      = (state_q == GRANT) && axis.s_axis_tvalid[grant_q] && load;
    burst_end   = (MAX_BURST != 0) && (int'(beat_cnt_q) == MAX_BURST - 1);
    release_now = accept && (axis.s_axis_tlast[grant_q] || burst_end);
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_tid_d    = m_tid_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = pick;
        end
      end
      GRANT: begin
        if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
        if (release_now) begin
          state_d    = IDLE;
          rr_ptr_d   = (grant_q == IW'(N - 1)) ? '0 : grant_q + 1'b1;
          beat_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Payload fields keep their last value when no beat loads.
    if (accept) begin
      m_data_d  = axis.s_axis_tdata[grant_q];
      m_last_d  = axis.s_axis_tlast[grant_q];
      m_tid_d   = TIDW'(grant_q);
      m_valid_d = 1'b1;
    end else if (m_valid_q && axis.m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_tid_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_tid_q    <= m_tid_d;
    end
  end

  assign axis.s_axis_tready = tready;
  assign axis.m_axis_tdata  = m_data_q;
  assign axis.m_axis_tvalid = m_valid_q;
  assign axis.m_axis_tlast  = m_last_q;
  assign axis.m_axis_tid    = m_tid_q;
  assign busy               = (state_q == GRANT);
  assign grant_id           = grant_q;

endmodule
